// File: rtl/srcmux_pipe.sv
// Indexed operand-source select feeding a 2-entry valid/ready skid buffer.
// Optional `SRCMUX_ERR_CNT_EN adds a saturating out-of-range select counter (err_cnt).
module srcmux_pipe #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH*NUM_SRC-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err,
    output logic                     out_valid,
`ifdef SRCMUX_ERR_CNT_EN
    output logic [7:0]               err_cnt,
`endif
    input  logic                     out_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state, state_next;
    logic             accept, pop;
    logic [WIDTH-1:0] word;
    logic             word_err;
    logic [WIDTH-1:0] head_data, tail_data;
    logic             head_err, tail_err;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first; any path that skipped it would infer a latch.
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !pop)      state_next = TWO;
                else if (!accept && pop) state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags decode only the registered state, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state == EMPTY) || (state == ONE);
        out_valid = (state == ONE) || (state == TWO);
    end

    always_comb begin
        word     = '0;
        word_err = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                word     = src_bus[k*WIDTH +: WIDTH];
                word_err = 1'b0;
            end
        end
    end

    // NOTE: both buffer entries are reset so out_data reads 0 after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_err  <= 1'b0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    head_data <= word;
                    head_err  <= word_err;
                end
                ONE: begin
                    if (accept && pop) begin
                        head_data <= word;
                        head_err  <= word_err;
                    end else if (accept) begin
                        tail_data <= word;
                        tail_err  <= word_err;
                    end
                end
                TWO: if (pop) begin
                    head_data <= tail_data;
                    head_err  <= tail_err;
                end
                default: ;
            endcase
        end
    end

    assign out_data = head_data;
    assign out_err  = head_err;

`ifdef SRCMUX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   err_cnt <= 8'd0;
        else if (accept && word_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_srcmux_pipe.sv
// Scoreboard bench for srcmux_pipe: three instances (4, 3 and 2 sources) share one stimulus stream.
// Expected words come from a plain index/range model; FIFO depth is tracked by queue size.
module tb_srcmux_pipe;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] src_bus = '0;
    logic [1:0]  sel = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir [3];
    logic        ov [3];
    logic [15:0] od [3];
    logic        oe [3];

    exp_t        q [3][$];
    int          checks = 0;
    int          errors = 0;
    int          err_model = 0;

    always #5 clk = ~clk;

`ifdef SRCMUX_ERR_CNT_EN
    logic [7:0] err_cnt4, err_cnt3, err_cnt2;
`endif

    srcmux_pipe #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .src_bus(src_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[0]), .out_data(od[0]), .out_err(oe[0]), .out_valid(ov[0]),
`ifdef SRCMUX_ERR_CNT_EN
        .err_cnt(err_cnt4),
`endif
        .out_ready(out_ready));

    srcmux_pipe #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .src_bus(src_bus[47:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[1]), .out_data(od[1]), .out_err(oe[1]), .out_valid(ov[1]),
`ifdef SRCMUX_ERR_CNT_EN
        .err_cnt(err_cnt3),
`endif
        .out_ready(out_ready));

    srcmux_pipe #(.WIDTH(16), .NUM_SRC(2), .SEL_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_bus(src_bus[31:0]), .sel(sel[0:0]), .in_valid(in_valid),
        .in_ready(ir[2]), .out_data(od[2]), .out_err(oe[2]), .out_valid(ov[2]),
`ifdef SRCMUX_ERR_CNT_EN
        .err_cnt(err_cnt2),
`endif
        .out_ready(out_ready));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [63:0] src, input int s, input int n);
        exp_t e;
        if (s < n) e = '{data: src[s*16 +: 16], err: 1'b0};
        else       e = '{data: 16'h0, err: 1'b1};
        return e;
    endfunction

    function automatic int nsrc(input int i);
        return (i == 0) ? 4 : (i == 1) ? 3 : 2;
    endfunction

    // Scoreboard push: every completed input handshake enqueues the model's word.
    always @(posedge clk) begin
        if (rst_n && in_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (ir[i]) q[i].push_back(model(src_bus, (i == 2) ? int'(sel[0]) : int'(sel), nsrc(i)));
            end
            if (ir[1] && int'(sel) >= 3 && err_model < 255) err_model++;
        end
    end

    // Monitor: on the falling edge compare flags against queue depth and the head against the queue front.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                int sz;
                sz = q[i].size();
                check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(sz != 0));
                check($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(sz < 2));
                if (ov[i] && sz != 0) begin
                    check($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(q[i][0].data));
                    check($sformatf("out_err[%0d]", i), 32'(oe[i]), 32'(q[i][0].err));
                    if (out_ready) void'(q[i].pop_front());
                end
            end
`ifdef SRCMUX_ERR_CNT_EN
            check("err_cnt3", 32'(err_cnt3), 32'(err_model));
            check("err_cnt4", 32'(err_cnt4), 32'd0);
`endif
        end
    end

    task automatic cyc(input logic v, input logic [1:0] s, input logic rdy);
        in_valid  = v;
        sel       = s;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s out_valid[%0d]", tag, i), 32'(ov[i]), 32'd0);
            check($sformatf("%s in_ready[%0d]", tag, i), 32'(ir[i]), 32'd1);
            check($sformatf("%s out_data[%0d]", tag, i), 32'(od[i]), 32'd0);
            check($sformatf("%s out_err[%0d]", tag, i), 32'(oe[i]), 32'd0);
        end
    endtask

    initial begin
        #2;
        check_reset_state("por");
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single select, then a directed look one cycle after the accept.
        src_bus = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        cyc(1'b1, 2'd2, 1'b1);
        check("single data", 32'(od[0]), 32'hCCCC);
        check("single valid", 32'(ov[0]), 32'd1);
        check("single err", 32'(oe[0]), 32'd0);
        cyc(1'b0, 2'd0, 1'b1);

        // Backpressure fills both entries; head must hold until released.
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        check("bp in_ready low", 32'(ir[0]), 32'd0);
        check("bp head", 32'(od[0]), 32'hAAAA);
        cyc(1'b0, 2'd0, 1'b0);
        check("bp head hold", 32'(od[0]), 32'hAAAA);
        cyc(1'b0, 2'd0, 1'b1);
        check("bp second", 32'(od[0]), 32'hBBBB);
        check("bp in_ready back", 32'(ir[0]), 32'd1);
        cyc(1'b0, 2'd0, 1'b1);

        // Streaming: one word per cycle, A B C D A B C D.
        for (int k = 0; k < 8; k++) cyc(1'b1, 2'(k), 1'b1);
        check("stream in_ready", 32'(ir[0]), 32'd1);
        cyc(1'b0, 2'd0, 1'b1);

        // Out-of-range select on the 3-source instance; enough accepts to saturate the counter.
        cyc(1'b1, 2'd3, 1'b1);
        check("range data", 32'(od[1]), 32'd0);
        check("range err", 32'(oe[1]), 32'd1);
        for (int k = 0; k < 300; k++) cyc(1'b1, 2'd3, 1'b1);
`ifdef SRCMUX_ERR_CNT_EN
        check("err_cnt saturated", 32'(err_cnt3), 32'd255);
`endif
        cyc(1'b0, 2'd0, 1'b1);

        // Legacy S/DS equivalence on the 2-source instance.
        src_bus = {32'h0, 16'h5678, 16'h1234};
        cyc(1'b1, 2'd0, 1'b1);
        check("legacy S", 32'(od[2]), 32'h1234);
        cyc(1'b1, 2'd1, 1'b1);
        check("legacy DS", 32'(od[2]), 32'h5678);
        cyc(1'b0, 2'd0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            src_bus = {$urandom, $urandom};
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        // Reset mid-stream with two entries held.
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        for (int i = 0; i < 3; i++) q[i].delete();
        err_model = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #13 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
